wb_mem_responder: RTL and testbench
===================================

Name: wb_mem_responder

Overview:
- Wishbone classic-cycle slave answering the user-area window: backing word memory plus a 3-register DMA control/status bank.
- Serves both the firmware CPU and the DMA initiator, which issue stb/cyc/we/sel/adr and wait for ack.
- Memory accesses take a programmable number of wait states, modelling the external-memory latency.
- CSR accesses complete in 1 cycle; writing the control register generates the DMA start pulse.

Parameters:
BASE_ADDR, 32'h38000000, base of the memory window
MEM_WORDS, 192, 32-bit words in memory; window = BASE_ADDR .. BASE_ADDR+4*MEM_WORDS-1
CSR_BASE, 32'h380002AC, CTRL at +0, STATUS at +4, MAILBOX at +8
DELAYS, 10, wait-state cycles for memory accesses (0 legal)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  asynchronous, active-high reset
wbs_stb_i  in  1  strobe
wbs_cyc_i  in  1  cycle
wbs_we_i  in  1  1 = write
wbs_sel_i  in  4  byte enables, bit n = bits 8n+7:8n
wbs_adr_i  in  32  byte address; bits 1:0 ignored
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  one-cycle acknowledge
wbs_dat_o  out  32  read data, valid while ack high
dma_start_o  out  1  one-cycle DMA start pulse
dma_done_i  in  1  one-cycle DMA completion pulse
dma_busy_o  out  1  DMA-in-progress flag

Behaviour:
- Reset values, applied asynchronously: ack=0, dat_o=0, dma_start_o=0, dma_busy_o=0, STATUS.done=0, MAILBOX=0, FSM=IDLE, counter=0. Memory contents are not reset.
- Request = stb & cyc. It is accepted only in IDLE. On acceptance, adr, we, sel and dat are latched and later changes are ignored.
- FSM states: IDLE, WAIT, ACK.
- IDLE to WAIT: memory-hit request with DELAYS>0; counter loads DELAYS-1.
- IDLE to ACK: CSR or out-of-range request, or memory request with DELAYS=0.
- WAIT: counter decrements each cycle; at counter==0, go to ACK.
- WAIT to IDLE (abort): stb or cyc low in any WAIT cycle. No ack is issued and no write occurs.
- ACK: ack=1 for exactly one cycle, then IDLE.
- A request held high in the cycle after ack is a new request and is accepted in that IDLE cycle. Back-to-back throughput is therefore one access per DELAYS+2 cycles.
- Latency, counting request-sample cycle as 0: memory ack in cycle DELAYS+1; CSR ack in cycle 1.
- Memory write: commits on the edge entering ACK, only bytes with sel=1. sel=0000 acks with no change.
- Memory read: dat_o is registered on the edge entering ACK. A read issued after a write returns the new data.
- dat_o = 0 whenever ack = 0.
- Out-of-range address (neither window nor CSR): acks in 1 cycle, read data 0, write ignored. The slave never hangs.
- CTRL (+0): write with sel[0]=1 and dat[0]=1 drives dma_start_o high in the ACK cycle and sets busy on the same edge. A write with dat[0]=1 while busy is ignored (no pulse). Read returns {30'b0, done, busy}.
- STATUS (+4): bit0 = done, sticky. Set by dma_done_i; cleared by write with sel[0]=1 and dat[0]=1 (W1C). dma_done_i and W1C in the same cycle: set wins. dma_done_i also clears busy. Read returns {31'b0, done}.
- MAILBOX (+8): plain 32-bit R/W register with byte enables.
- dma_done_i while not busy: sets done, busy stays 0.
- Reset asserted mid-transfer: FSM returns to IDLE immediately, no ack. Outstanding writes are dropped.

Test Plan:
- DELAYS=10: write 0xDEADBEEF to 0x38000100 (sel=1111), then read 0x38000100. Each ack arrives exactly 11 cycles after stb; read returns 0xDEADBEEF.
- Byte enables: write 0x11223344 to 0x38000104, then write 0xAABBCCDD with sel=0101. Read returns 0x11BB33DD.
- Abort: read request dropped after 4 WAIT cycles; next read to 0x38000100. No ack for the first request; second acks at +11 cycles with correct data.
- DMA control sequence:
  - Write 1 to 0x380002AC: ack at +1 with dma_start_o high in the same cycle; CTRL read returns 0x1.
  - Second start write while busy: no pulse.
  - Pulse dma_done_i: CTRL read returns 0x2.
  - W1C to 0x380002B0 in the same cycle as dma_done_i: done stays 1.
- Out-of-range read at 0x38000400: ack at +1, data 0x00000000. Back-to-back reads with stb held high: acks spaced exactly DELAYS+2 cycles apart.
- Assert reset during WAIT: ack stays 0, dma_busy_o=0, next request serviced normally.

Source files
------------

// File: rtl/wb_mem_responder_if.sv
// Wishbone classic slave bus bundle for the user-area memory/CSR responder.
interface wb_mem_responder_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_mem_responder.sv
// Wishbone slave: word memory with DELAYS wait states (ack at DELAYS+1) plus DMA CSR bank (ack at 1).
// Master holds stb/cyc until ack; dropping either during wait states aborts the access without ack.
module wb_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
  parameter int          MEM_WORDS = 192,
  parameter logic [31:0] CSR_BASE  = 32'h3800_02AC,
  parameter int          DELAYS    = 10
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  wb_mem_responder_if.slave   bus,
  output logic                dma_start_o,
  input  logic                dma_done_i,
  output logic                dma_busy_o
);

  localparam int          IW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int          CW      = (DELAYS > 1) ? $clog2(DELAYS) : 1;
  localparam logic [31:0] MEM_END = BASE_ADDR + 32'(4 * MEM_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   adr_q, dat_q;
  logic          we_q;
  logic [3:0]    sel_q;
  logic          done, busy;
  logic [31:0]   mailbox;
  logic [31:0]   mem [MEM_WORDS];

  logic        req;
  logic [31:0] acc_adr, acc_dat;
  logic        acc_we;
  logic [3:0]  acc_sel;

  assign req = bus.wbs_stb_i & bus.wbs_cyc_i;

  // In IDLE the live bus is decoded; afterwards only the latched request matters.
  assign acc_adr = (state == IDLE) ? bus.wbs_adr_i : adr_q;
  assign acc_dat = (state == IDLE) ? bus.wbs_dat_i : dat_q;
  assign acc_we  = (state == IDLE) ? bus.wbs_we_i  : we_q;
  assign acc_sel = (state == IDLE) ? bus.wbs_sel_i : sel_q;

  logic [29:0]   csr_off;
  logic [31:0]   mem_off;
  logic          csr_hit, mem_hit;
  logic [1:0]    csr_reg;
  logic [IW-1:0] idx;

  // CSRs sit inside the memory window, so they take priority.
  assign csr_off = acc_adr[31:2] - CSR_BASE[31:2];
  assign csr_hit = (csr_off < 30'd3);
  assign csr_reg = csr_off[1:0];
  assign mem_hit = !csr_hit && (acc_adr[31:2] >= BASE_ADDR[31:2]) && (acc_adr[31:2] < MEM_END[31:2]);
  assign mem_off = acc_adr - BASE_ADDR;
  assign idx     = mem_off[IW+1:2];

  logic unused_bits;
  assign unused_bits = &{1'b0, mem_off[31:IW+2], mem_off[1:0]};

  logic mem_commit, csr_wr, start_fire, w1c;
  logic [31:0] csr_rdata;

  assign mem_commit = mem_hit && req &&
                      ((state == WAIT && cnt == '0) || (state == IDLE && DELAYS == 0));
  assign csr_wr     = (state == IDLE) && req && csr_hit && acc_we;
  assign start_fire = csr_wr && csr_reg == 2'd0 && acc_sel[0] && acc_dat[0] && !busy;
  assign w1c        = csr_wr && csr_reg == 2'd1 && acc_sel[0] && acc_dat[0];

  always_comb begin
    csr_rdata = '0;
    case (csr_reg)
      2'd0:    csr_rdata = {30'b0, done, busy};
      2'd1:    csr_rdata = {31'b0, done};
      2'd2:    csr_rdata = mailbox;
      default: csr_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (mem_commit && acc_we && !wb_rst_i) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_sel[b]) mem[idx][8*b +: 8] <= acc_dat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      cnt           <= '0;
      adr_q         <= '0;
      dat_q         <= '0;
      we_q          <= 1'b0;
      sel_q         <= '0;
      bus.wbs_ack_o <= 1'b0;
      bus.wbs_dat_o <= '0;
      dma_start_o   <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      mailbox       <= '0;
    end else begin
      dma_start_o <= start_fire;
      if (dma_done_i)  done <= 1'b1;
      else if (w1c)    done <= 1'b0;
      if (start_fire)      busy <= 1'b1;
      else if (dma_done_i) busy <= 1'b0;
      if (csr_wr && csr_reg == 2'd2) begin
        for (int b = 0; b < 4; b++) begin
          if (acc_sel[b]) mailbox[8*b +: 8] <= acc_dat[8*b +: 8];
        end
      end

      case (state)
        IDLE: begin
          bus.wbs_ack_o <= 1'b0;
          bus.wbs_dat_o <= '0;
          if (req) begin
            adr_q <= bus.wbs_adr_i;
            dat_q <= bus.wbs_dat_i;
            we_q  <= bus.wbs_we_i;
            sel_q <= bus.wbs_sel_i;
            if (mem_hit && DELAYS > 0) begin
              state <= WAIT;
              cnt   <= CW'(DELAYS - 1);
            end else begin
              state         <= ACK;
              bus.wbs_ack_o <= 1'b1;
              if (!acc_we) begin
                if (csr_hit)      bus.wbs_dat_o <= csr_rdata;
                else if (mem_hit) bus.wbs_dat_o <= mem[idx];
              end
            end
          end
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state         <= ACK;
            bus.wbs_ack_o <= 1'b1;
            bus.wbs_dat_o <= acc_we ? 32'h0 : mem[idx];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.wbs_ack_o <= 1'b0;
          bus.wbs_dat_o <= '0;
        end
      endcase
    end
  end

  assign dma_busy_o = busy;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench for wb_mem_responder: latency, byte enables, abort, DMA CSRs, out-of-range, reset.
module tb_wb_mem_responder;
  logic clk = 1'b0;
  logic rst;
  logic dma_start, dma_done, dma_busy;
  int   n_chk = 0;
  int   n_pass = 0;

  wb_mem_responder_if bus();

  wb_mem_responder dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .bus         (bus),
    .dma_start_o (dma_start),
    .dma_done_i  (dma_done),
    .dma_busy_o  (dma_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic bus_idle();
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
  endtask

  task automatic bus_req(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] wdat);
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = wdat;
  endtask

  // Latency is the cycle index of ack, counting the request-sample cycle as 0; -1 if none.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] wdat, input logic done_pulse,
                      output logic [31:0] rdat, output int lat, output logic start_seen);
    @(posedge clk); #1;
    bus_req(we, adr, sel, wdat);
    dma_done = done_pulse;
    lat = -1; rdat = 32'h0; start_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 1) dma_done = 1'b0;
      if (bus.wbs_ack_o) begin
        lat = c; rdat = bus.wbs_dat_o; start_seen = dma_start;
        break;
      end
    end
    @(posedge clk); #1;
    bus_idle();
    dma_done = 1'b0;
  endtask

  task automatic count_acks(input int cycles, output int acks);
    acks = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) acks++;
    end
  endtask

  logic [31:0] rd;
  int          lat, acks, first_ack, second_ack, bad_dat;
  logic        st;
  logic [31:0] second_dat;

  initial begin
    rst = 1'b1;
    dma_done = 1'b0;
    bus_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", {31'b0, bus.wbs_ack_o}, 32'h0);
    chk("rst_dat", bus.wbs_dat_o, 32'h0);
    chk("rst_start", {31'b0, dma_start}, 32'h0);
    chk("rst_busy", {31'b0, dma_busy}, 32'h0);
    rst = 1'b0;

    xfer(1'b1, 32'h3800_0100, 4'hF, 32'hDEAD_BEEF, 1'b0, rd, lat, st);
    chk("wr_lat", lat, 11);
    xfer(1'b0, 32'h3800_0100, 4'hF, 32'h0, 1'b0, rd, lat, st);
    chk("rd_lat", lat, 11);
    chk("rd_dat", rd, 32'hDEAD_BEEF);

    xfer(1'b1, 32'h3800_0104, 4'hF, 32'h1122_3344, 1'b0, rd, lat, st);
    xfer(1'b1, 32'h3800_0104, 4'h5, 32'hAABB_CCDD, 1'b0, rd, lat, st);
    xfer(1'b0, 32'h3800_0104, 4'hF, 32'h0, 1'b0, rd, lat, st);
    chk("sel_merge", rd, 32'h11BB_33DD);

    // Abort: request held through cycle 4 (four WAIT cycles), dropped in cycle 5.
    @(posedge clk); #1;
    bus_req(1'b0, 32'h3800_0100, 4'hF, 32'h0);
    count_acks(5, acks);
    @(posedge clk); #1;
    bus_idle();
    begin
      int more;
      count_acks(15, more);
      acks += more;
    end
    chk("abort_noack", acks, 0);
    xfer(1'b0, 32'h3800_0100, 4'hF, 32'h0, 1'b0, rd, lat, st);
    chk("post_abort_lat", lat, 11);
    chk("post_abort_dat", rd, 32'hDEAD_BEEF);

    xfer(1'b1, 32'h3800_02AC, 4'h1, 32'h1, 1'b0, rd, lat, st);
    chk("start_lat", lat, 1);
    chk("start_pulse", {31'b0, st}, 32'h1);
    chk("busy_set", {31'b0, dma_busy}, 32'h1);
    xfer(1'b0, 32'h3800_02AC, 4'hF, 32'h0, 1'b0, rd, lat, st);
    chk("ctrl_busy", rd, 32'h1);
    xfer(1'b1, 32'h3800_02AC, 4'h1, 32'h1, 1'b0, rd, lat, st);
    chk("restart_nopulse", {31'b0, st}, 32'h0);

    @(posedge clk); #1 dma_done = 1'b1;
    @(posedge clk); #1 dma_done = 1'b0;
    @(negedge clk);
    chk("busy_clr", {31'b0, dma_busy}, 32'h0);
    xfer(1'b0, 32'h3800_02AC, 4'hF, 32'h0, 1'b0, rd, lat, st);
    chk("ctrl_done", rd, 32'h2);

    xfer(1'b1, 32'h3800_02B0, 4'h1, 32'h1, 1'b1, rd, lat, st);
    xfer(1'b0, 32'h3800_02B0, 4'hF, 32'h0, 1'b0, rd, lat, st);
    chk("w1c_vs_set", rd, 32'h1);
    xfer(1'b1, 32'h3800_02B0, 4'h1, 32'h1, 1'b0, rd, lat, st);
    xfer(1'b0, 32'h3800_02B0, 4'hF, 32'h0, 1'b0, rd, lat, st);
    chk("w1c_clear", rd, 32'h0);

    xfer(1'b1, 32'h3800_02B4, 4'hF, 32'h1234_5678, 1'b0, rd, lat, st);
    xfer(1'b1, 32'h3800_02B4, 4'h1, 32'h0000_00FF, 1'b0, rd, lat, st);
    xfer(1'b0, 32'h3800_02B4, 4'hF, 32'h0, 1'b0, rd, lat, st);
    chk("mailbox", rd, 32'h1234_56FF);

    xfer(1'b1, 32'h3800_0400, 4'hF, 32'h5555_AAAA, 1'b0, rd, lat, st);
    chk("oor_wr_lat", lat, 1);
    xfer(1'b0, 32'h3800_0400, 4'hF, 32'h0, 1'b0, rd, lat, st);
    chk("oor_rd_lat", lat, 1);
    chk("oor_rd_dat", rd, 32'h0);

    // Back-to-back reads with stb held: acks at cycles 11 and 23.
    @(posedge clk); #1;
    bus_req(1'b0, 32'h3800_0100, 4'hF, 32'h0);
    first_ack = -1; second_ack = -1; bad_dat = 0; second_dat = 32'h0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) begin
        if (first_ack < 0) first_ack = c;
        else if (second_ack < 0) begin
          second_ack = c; second_dat = bus.wbs_dat_o;
        end
      end else if (bus.wbs_dat_o != 32'h0) bad_dat++;
    end
    @(posedge clk); #1;
    bus_idle();
    repeat (3) @(posedge clk);
    chk("b2b_first", first_ack, 11);
    chk("b2b_second", second_ack, 23);
    chk("b2b_dat", second_dat, 32'hDEAD_BEEF);
    chk("dat_zero_noack", bad_dat, 0);

    // Reset during WAIT drops the pending write and the DMA busy flag.
    xfer(1'b1, 32'h3800_0108, 4'hF, 32'h0101_0101, 1'b0, rd, lat, st);
    xfer(1'b1, 32'h3800_02AC, 4'h1, 32'h1, 1'b0, rd, lat, st);
    chk("busy_pre_rst", {31'b0, dma_busy}, 32'h1);
    @(posedge clk); #1;
    bus_req(1'b1, 32'h3800_0108, 4'hF, 32'hCAFE_F00D);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    bus_idle();
    @(negedge clk);
    chk("rst_wait_ack", {31'b0, bus.wbs_ack_o}, 32'h0);
    chk("rst_wait_busy", {31'b0, dma_busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    count_acks(15, acks);
    chk("rst_wait_noack", acks, 0);
    xfer(1'b0, 32'h3800_0108, 4'hF, 32'h0, 1'b0, rd, lat, st);
    chk("post_rst_lat", lat, 11);
    chk("post_rst_dat", rd, 32'h0101_0101);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
